// File: rtl/inst_fetch.sv
// Instruction fetch front end: fetch PC, 2-entry {pc, inst} buffer toward decode,
// redirect handling with wrong-path flush, sticky misalignment flag and delivery count.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_inst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc4,
   output logic        misalign_err,
   output logic [31:0] deliver_cnt
);

   logic [31:0] fetch_pc;
   logic [31:0] head_pc, head_inst;
   logic [31:0] tail_pc, tail_inst;
   logic [1:0]  count;
   logic        push, pop;

   assign imem_addr = fetch_pc;
   assign out_valid = (count != 2'd0);
   assign out_pc    = head_pc;
   assign out_inst  = head_inst;
   // Head is zeroed whenever the buffer empties, so this yields 4 when empty
   assign out_pc4   = head_pc + 32'd4;

   assign pop  = out_valid & out_ready;
   assign push = !redirect_valid & ((count < 2'd2) | pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc     <= RESET_PC;
         count        <= '0;
         head_pc      <= '0;
         head_inst    <= '0;
         tail_pc      <= '0;
         tail_inst    <= '0;
         misalign_err <= 1'b0;
         deliver_cnt  <= '0;
      end else begin
         if (pop)
            deliver_cnt <= deliver_cnt + 32'd1;

         if (redirect_valid) begin
            fetch_pc  <= {redirect_pc[31:2], 2'b00};
            count     <= '0;
            head_pc   <= '0;
            head_inst <= '0;
            if (redirect_pc[1:0] != 2'b00)
               misalign_err <= 1'b1;
         end else begin
            if (push)
               fetch_pc <= fetch_pc + 32'd4;

            // Shift-style buffer: head always holds the oldest entry
            unique case ({push, pop})
               2'b10: begin
                  if (count == 2'd0) begin
                     head_pc   <= fetch_pc;
                     head_inst <= imem_inst;
                  end else begin
                     tail_pc   <= fetch_pc;
                     tail_inst <= imem_inst;
                  end
                  count <= count + 2'd1;
               end
               2'b01: begin
                  if (count == 2'd2) begin
                     head_pc   <= tail_pc;
                     head_inst <= tail_inst;
                  end else begin
                     head_pc   <= '0;
                     head_inst <= '0;
                  end
                  count <= count - 2'd1;
               end
               2'b11: begin
                  if (count == 2'd2) begin
                     head_pc   <= tail_pc;
                     head_inst <= tail_inst;
                     tail_pc   <= fetch_pc;
                     tail_inst <= imem_inst;
                  end else begin
                     head_pc   <= fetch_pc;
                     head_inst <= imem_inst;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: per-cycle vector table on a RESET_PC=0 instance,
// plus a hand sequence on a second instance exercising address wraparound.
module tb_inst_fetch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   function automatic logic [31:0] prog(input logic [31:0] a);
      case (a)
         32'h00: prog = 32'h2001_0005;
         32'h04: prog = 32'h2002_0006;
         32'h08: prog = 32'h0001_0814;
         32'h0C: prog = 32'h1022_0002;
         32'h10: prog = 32'h2003_0007;
         32'h14: prog = 32'h0000_0000;
         32'h18: prog = 32'h2004_000A;
         32'h1C: prog = 32'h0800_0000;
         32'h20: prog = 32'hAC01_0000;
         32'h24: prog = 32'h8C02_0000;
         32'h28: prog = 32'h0022_1820;
         32'h2C: prog = 32'h0C00_0010;
         default: prog = {a[31:2], 2'b11};
      endcase
   endfunction

   // Main instance
   logic        rst, rv, rdy;
   logic [31:0] rpc, addr, inst, opc, oinst, opc4, dcnt;
   logic        oval, mis;

   assign inst = prog(addr);

   inst_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .rst(rst), .imem_addr(addr), .imem_inst(inst),
      .redirect_valid(rv), .redirect_pc(rpc),
      .out_valid(oval), .out_ready(rdy), .out_inst(oinst), .out_pc(opc),
      .out_pc4(opc4), .misalign_err(mis), .deliver_cnt(dcnt)
   );

   // Wraparound instance
   logic        h_rst, h_rdy, h_oval, h_mis;
   logic [31:0] h_addr, h_inst, h_opc, h_oinst, h_opc4, h_dcnt;

   assign h_inst = prog(h_addr);

   inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
      .clk(clk), .rst(h_rst), .imem_addr(h_addr), .imem_inst(h_inst),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .out_valid(h_oval), .out_ready(h_rdy), .out_inst(h_oinst), .out_pc(h_opc),
      .out_pc4(h_opc4), .misalign_err(h_mis), .deliver_cnt(h_dcnt)
   );

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   typedef struct {
      logic        rst, rv, rdy;
      logic [31:0] rpc;
      logic        e_val;
      logic [31:0] e_pc, e_inst, e_pc4, e_addr;
      logic        e_mis;
      logic [31:0] e_dcnt;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic v, input logic [31:0] p,
                               input logic y, input logic ev, input logic [31:0] epc,
                               input logic [31:0] ei, input logic [31:0] ep4,
                               input logic [31:0] ea, input logic em,
                               input logic [31:0] ed);
      vec_t t;
      t.rst = r; t.rv = v; t.rpc = p; t.rdy = y;
      t.e_val = ev; t.e_pc = epc; t.e_inst = ei; t.e_pc4 = ep4;
      t.e_addr = ea; t.e_mis = em; t.e_dcnt = ed;
      return t;
   endfunction

   vec_t vecs[28];

   initial begin
      // rst rv  rpc    rdy | val pc   inst          pc4    addr   mis dcnt
      vecs[0]  = mk(1, 0, 32'h0,  1, 0, 32'h0,  32'h0,         32'h4,  32'h0,  0, 0);
      vecs[1]  = mk(0, 0, 32'h0,  1, 1, 32'h0,  32'h2001_0005, 32'h4,  32'h4,  0, 0);
      vecs[2]  = mk(0, 0, 32'h0,  1, 1, 32'h4,  32'h2002_0006, 32'h8,  32'h8,  0, 1);
      vecs[3]  = mk(0, 0, 32'h0,  1, 1, 32'h8,  32'h0001_0814, 32'hC,  32'hC,  0, 2);
      vecs[4]  = mk(0, 0, 32'h0,  1, 1, 32'hC,  32'h1022_0002, 32'h10, 32'h10, 0, 3);
      vecs[5]  = mk(0, 1, 32'h1C, 1, 0, 32'h0,  32'h0,         32'h4,  32'h1C, 0, 4);
      vecs[6]  = mk(0, 0, 32'h0,  1, 1, 32'h1C, 32'h0800_0000, 32'h20, 32'h20, 0, 4);
      vecs[7]  = mk(0, 0, 32'h0,  0, 1, 32'h1C, 32'h0800_0000, 32'h20, 32'h24, 0, 4);
      vecs[8]  = mk(0, 0, 32'h0,  0, 1, 32'h1C, 32'h0800_0000, 32'h20, 32'h24, 0, 4);
      vecs[9]  = mk(0, 0, 32'h0,  1, 1, 32'h20, 32'hAC01_0000, 32'h24, 32'h28, 0, 5);
      vecs[10] = mk(0, 0, 32'h0,  1, 1, 32'h24, 32'h8C02_0000, 32'h28, 32'h2C, 0, 6);
      vecs[11] = mk(0, 1, 32'h16, 1, 0, 32'h0,  32'h0,         32'h4,  32'h14, 1, 7);
      vecs[12] = mk(0, 0, 32'h0,  1, 1, 32'h14, 32'h0,         32'h18, 32'h18, 1, 7);
      vecs[13] = mk(0, 0, 32'h0,  1, 1, 32'h18, 32'h2004_000A, 32'h1C, 32'h1C, 1, 8);
      vecs[14] = mk(0, 1, 32'h1C, 0, 0, 32'h0,  32'h0,         32'h4,  32'h1C, 1, 8);
      vecs[15] = mk(0, 0, 32'h0,  0, 1, 32'h1C, 32'h0800_0000, 32'h20, 32'h20, 1, 8);
      vecs[16] = mk(0, 0, 32'h0,  0, 1, 32'h1C, 32'h0800_0000, 32'h20, 32'h24, 1, 8);
      vecs[17] = mk(1, 1, 32'h40, 1, 0, 32'h0,  32'h0,         32'h4,  32'h0,  0, 0);
      vecs[18] = mk(0, 0, 32'h0,  1, 1, 32'h0,  32'h2001_0005, 32'h4,  32'h4,  0, 0);
      vecs[19] = mk(1, 0, 32'h0,  0, 0, 32'h0,  32'h0,         32'h4,  32'h0,  0, 0);
      vecs[20] = mk(0, 0, 32'h0,  0, 1, 32'h0,  32'h2001_0005, 32'h4,  32'h4,  0, 0);
      vecs[21] = mk(0, 0, 32'h0,  0, 1, 32'h0,  32'h2001_0005, 32'h4,  32'h8,  0, 0);
      vecs[22] = mk(0, 0, 32'h0,  0, 1, 32'h0,  32'h2001_0005, 32'h4,  32'h8,  0, 0);
      vecs[23] = mk(0, 0, 32'h0,  0, 1, 32'h0,  32'h2001_0005, 32'h4,  32'h8,  0, 0);
      vecs[24] = mk(0, 0, 32'h0,  0, 1, 32'h0,  32'h2001_0005, 32'h4,  32'h8,  0, 0);
      vecs[25] = mk(0, 0, 32'h0,  1, 1, 32'h4,  32'h2002_0006, 32'h8,  32'hC,  0, 1);
      vecs[26] = mk(0, 0, 32'h0,  1, 1, 32'h8,  32'h0001_0814, 32'hC,  32'h10, 0, 2);
      vecs[27] = mk(0, 0, 32'h0,  1, 1, 32'hC,  32'h1022_0002, 32'h10, 32'h14, 0, 3);

      h_rst = 1'b1;
      h_rdy = 1'b1;

      for (int i = 0; i < 28; i++) begin
         rst = vecs[i].rst;
         rv  = vecs[i].rv;
         rpc = vecs[i].rpc;
         rdy = vecs[i].rdy;
         @(posedge clk);
         #1;
         chk("out_valid",    i, {31'b0, oval}, {31'b0, vecs[i].e_val});
         chk("out_pc",       i, opc,           vecs[i].e_pc);
         chk("out_inst",     i, oinst,         vecs[i].e_inst);
         chk("out_pc4",      i, opc4,          vecs[i].e_pc4);
         chk("imem_addr",    i, addr,          vecs[i].e_addr);
         chk("misalign_err", i, {31'b0, mis},  {31'b0, vecs[i].e_mis});
         chk("deliver_cnt",  i, dcnt,          vecs[i].e_dcnt);
      end

      // Wraparound sequence from RESET_PC = FFFF_FFF8
      rst = 1'b1;
      rv  = 1'b0;
      h_rst = 1'b1;
      @(posedge clk);
      #1;
      chk("hi_reset_valid", 0, {31'b0, h_oval}, 32'h0);
      chk("hi_reset_addr",  0, h_addr,          32'hFFFF_FFF8);
      chk("hi_reset_pc4",   0, h_opc4,          32'h4);
      h_rst = 1'b0;
      @(posedge clk);
      #1;
      chk("hi_pc",   1, h_opc,   32'hFFFF_FFF8);
      chk("hi_inst", 1, h_oinst, 32'hFFFF_FFFB);
      chk("hi_pc4",  1, h_opc4,  32'hFFFF_FFFC);
      @(posedge clk);
      #1;
      chk("hi_pc",   2, h_opc,   32'hFFFF_FFFC);
      chk("hi_inst", 2, h_oinst, 32'hFFFF_FFFF);
      chk("hi_pc4",  2, h_opc4,  32'h0);
      chk("hi_addr", 2, h_addr,  32'h0);
      @(posedge clk);
      #1;
      chk("hi_pc",   3, h_opc,   32'h0);
      chk("hi_inst", 3, h_oinst, 32'h2001_0005);
      chk("hi_pc4",  3, h_opc4,  32'h4);
      @(posedge clk);
      #1;
      chk("hi_pc",    4, h_opc,  32'h4);
      chk("hi_valid", 4, {31'b0, h_oval}, 32'h1);
      chk("hi_dcnt",  4, h_dcnt, 32'h3);
      chk("hi_mis",   4, {31'b0, h_mis},  32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
